// File: rtl/whack_pkg.sv
// Shared types, default geometry and helpers for the whack game sequencer.
package whack_pkg;

  // Default game geometry; the top-level parameters start from these values.
  localparam int DEF_MAX_MS    = 2047;
  localparam int DEF_LED_NUM   = 18;
  localparam int DEF_ROUNDS    = 10;
  localparam int DEF_MAX_LIVES = 3;

  // Field widths derived from the default geometry.
  localparam int TIMER_W = $clog2(DEF_MAX_MS);
  localparam int IDX_W   = $clog2(DEF_LED_NUM);
  localparam int SCORE_W = $clog2(DEF_ROUNDS + 1);
  localparam int LIVES_W = $clog2(DEF_MAX_LIVES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GAP  = 3'd1,
    SHOW = 3'd2,
    HIT  = 3'd3,
    MISS = 3'd4,
    OVER = 3'd5
  } state_t;

  // Shrink the LED-on window by one step, never dropping below the floor.
  // Done in plain int arithmetic so the subtraction can never wrap.
  function automatic int shrink_on_time(input int cur, input int step, input int floor_v);
    if (cur >= floor_v + step) begin
      return cur - step;
    end else begin
      return floor_v;
    end
  endfunction

endpackage

// File: rtl/whack_round_scheduler_round_judge.sv
// Round judge: holds the target LED and the switch snapshot taken at the
// start of the lit window, and decides hit/miss from the toggles since then.
module round_judge
  import whack_pkg::*;
#(
  parameter int LED_NUM_P = DEF_LED_NUM,
  parameter int TIMER_W_P = TIMER_W,
  parameter int IDX_W_P   = IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture_i,
  input  logic [LED_NUM_P-1:0] switches_i,
  input  logic [IDX_W_P-1:0]   random_value_i,
  input  logic [TIMER_W_P-1:0] timer_value_i,
  input  logic [TIMER_W_P-1:0] on_time_i,
  output logic [LED_NUM_P-1:0] target_o,
  output logic                 hit_o,
  output logic                 miss_o
);

  localparam logic [LED_NUM_P-1:0] ONE_HOT0 = {{(LED_NUM_P-1){1'b0}}, 1'b1};

  logic [LED_NUM_P-1:0] target_q, target_d;
  logic [LED_NUM_P-1:0] snap_q, snap_d;
  logic [LED_NUM_P-1:0] diff_s;
  logic [IDX_W_P-1:0]   idx_s;

  // The random source may exceed the LED count, so fold it into range.
  assign idx_s = IDX_W_P'(32'(random_value_i) % 32'(LED_NUM_P));

  // Load a new target and snapshot when the dark gap ends, otherwise hold.
  always_comb begin
    target_d = target_q;
    snap_d   = snap_q;
    if (capture_i) begin
      target_d = ONE_HOT0 << idx_s;
      snap_d   = switches_i;
    end else begin
      target_d = target_q;
      snap_d   = snap_q;
    end
  end

  // Target and snapshot registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= {LED_NUM_P{1'b0}};
      snap_q   <= {LED_NUM_P{1'b0}};
    end else begin
      target_q <= target_d;
      snap_q   <= snap_d;
    end
  end

  // A hit is exactly the target toggled; anything else toggled, or running
  // out of time, is a miss. A hit on the timeout cycle still counts as a hit.
  assign diff_s   = switches_i ^ snap_q;
  assign hit_o    = (target_q != {LED_NUM_P{1'b0}}) && (diff_s == target_q);
  assign miss_o   = !hit_o && ((diff_s != {LED_NUM_P{1'b0}}) || (timer_value_i >= on_time_i));
  assign target_o = target_q;

endmodule

// File: rtl/whack_round_scheduler.sv
// Whack game sequencer: drives the shared ms timer through gap and lit
// windows, draws targets, judges rounds and keeps score/lives/round/on-time.
module whack_round_scheduler
  import whack_pkg::*;
#(
  parameter int MAX_MS      = DEF_MAX_MS,
  parameter int LED_NUM     = DEF_LED_NUM,
  parameter int ROUNDS      = DEF_ROUNDS,
  parameter int START_ON_MS = 1000,
  parameter int MIN_ON_MS   = 250,
  parameter int STEP_MS     = 75,
  parameter int GAP_MS      = 500,
  parameter int MAX_LIVES   = DEF_MAX_LIVES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_MS)-1:0]      timer_value,
  input  logic [$clog2(LED_NUM)-1:0]     random_value,
  input  logic [LED_NUM-1:0]             switches,
  output logic                           timer_reset,
  output logic                           timer_up,
  output logic                           timer_enable,
  output logic                           rng_advance,
  output logic [LED_NUM-1:0]             led_on,
  output logic [$clog2(ROUNDS+1)-1:0]    score,
  output logic [$clog2(MAX_LIVES+1)-1:0] lives,
  output logic [$clog2(ROUNDS+1)-1:0]    round_idx,
  output logic                           game_over
);

  localparam int TW = $clog2(MAX_MS);
  localparam int IW = $clog2(LED_NUM);
  localparam int SW = $clog2(ROUNDS + 1);
  localparam int LW = $clog2(MAX_LIVES + 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   score_q, score_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [SW-1:0]   round_q, round_d;
  logic [TW-1:0]   on_time_q, on_time_d;
  logic            start_q;

  logic            start_edge_s;
  logic            new_game_s;
  logic            capture_s;
  logic            hit_s;
  logic            miss_s;
  logic            last_round_s;
  logic [LED_NUM-1:0] target_s;

  logic            timer_reset_s;
  logic            timer_enable_s;
  logic            rng_advance_s;
  logic            game_over_s;
  logic [LED_NUM-1:0] led_on_s;

  assign start_edge_s = start && !start_q;
  assign last_round_s = (round_q == SW'(ROUNDS - 1));

  round_judge #(
    .LED_NUM_P (LED_NUM),
    .TIMER_W_P (TW),
    .IDX_W_P   (IW)
  ) u_judge (
    .clk            (clk),
    .reset          (reset),
    .capture_i      (capture_s),
    .switches_i     (switches),
    .random_value_i (random_value),
    .timer_value_i  (timer_value),
    .on_time_i      (on_time_q),
    .target_o       (target_s),
    .hit_o          (hit_s),
    .miss_o         (miss_s)
  );

  // State, counters and start-edge history; start_q is preset so a start
  // held through reset does not look like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      score_q   <= {SW{1'b0}};
      lives_q   <= {LW{1'b0}};
      round_q   <= {SW{1'b0}};
      on_time_q <= {TW{1'b0}};
      start_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      round_q   <= round_d;
      on_time_q <= on_time_d;
      start_q   <= start;
    end
  end

  // Next-state, counter updates and per-state output decode.
  always_comb begin
    state_d        = state_q;
    score_d        = score_q;
    lives_d        = lives_q;
    round_d        = round_q;
    on_time_d      = on_time_q;
    new_game_s     = 1'b0;
    capture_s      = 1'b0;
    timer_reset_s  = 1'b0;
    timer_enable_s = 1'b0;
    rng_advance_s  = 1'b0;
    game_over_s    = 1'b0;
    led_on_s       = {LED_NUM{1'b0}};

    case (state_q)
      IDLE: begin
        timer_reset_s = 1'b1;
        if (start_edge_s) begin
          new_game_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        timer_enable_s = 1'b1;
        if (timer_value == TW'(GAP_MS)) begin
          timer_reset_s = 1'b1;
          capture_s     = 1'b1;
          state_d       = SHOW;
        end else begin
          state_d = GAP;
        end
      end
      SHOW: begin
        timer_enable_s = 1'b1;
        led_on_s       = target_s;
        if (hit_s) begin
          state_d = HIT;
        end else if (miss_s) begin
          state_d = MISS;
        end else begin
          state_d = SHOW;
        end
      end
      HIT: begin
        timer_reset_s = 1'b1;
        rng_advance_s = 1'b1;
        score_d       = score_q + SW'(1);
        round_d       = round_q + SW'(1);
        on_time_d     = TW'(shrink_on_time(int'(on_time_q), STEP_MS, MIN_ON_MS));
        if (last_round_s) begin
          state_d = OVER;
        end else begin
          state_d = GAP;
        end
      end
      MISS: begin
        timer_reset_s = 1'b1;
        rng_advance_s = 1'b1;
        lives_d       = lives_q - LW'(1);
        round_d       = round_q + SW'(1);
        if ((lives_q == LW'(1)) || last_round_s) begin
          state_d = OVER;
        end else begin
          state_d = GAP;
        end
      end
      OVER: begin
        game_over_s = 1'b1;
        led_on_s    = {LED_NUM{1'b1}};
        if (start_edge_s) begin
          new_game_s = 1'b1;
        end else begin
          state_d = OVER;
        end
      end
      default: begin
        state_d       = IDLE;
        timer_reset_s = 1'b1;
      end
    endcase

    if (new_game_s) begin
      state_d   = GAP;
      score_d   = {SW{1'b0}};
      lives_d   = LW'(MAX_LIVES);
      round_d   = {SW{1'b0}};
      on_time_d = TW'(START_ON_MS);
    end else begin
      state_d = state_d;
    end
  end

  assign timer_reset  = timer_reset_s;
  assign timer_up     = 1'b1;
  assign timer_enable = timer_enable_s;
  // A reset landing on a HIT/MISS cycle must not consume a random value.
  assign rng_advance  = rng_advance_s && !reset;
  assign led_on       = led_on_s;
  assign score        = score_q;
  assign lives        = lives_q;
  assign round_idx    = round_q;
  assign game_over    = game_over_s;

endmodule

// File: tb/tb_whack_round_scheduler.sv
// Bench for whack_round_scheduler: plays the shared ms timer, compares every
// cycle against a rule-level game model, plus directed literal checks.
module tb_whack_round_scheduler;

  localparam int MAX_MS    = 2047;
  localparam int LED_NUM   = 18;
  localparam int ROUNDS    = 12;
  localparam int START_ON  = 1000;
  localparam int MIN_ON    = 250;
  localparam int STEP      = 75;
  localparam int GAP       = 500;
  localparam int MAX_LIVES = 3;
  localparam int TW = $clog2(MAX_MS);
  localparam int IW = $clog2(LED_NUM);
  localparam int SW = $clog2(ROUNDS + 1);
  localparam int LW = $clog2(MAX_LIVES + 1);

  logic clk = 1'b0;
  logic reset, start;
  logic [TW-1:0] tv = '0;
  logic [IW-1:0] rv;
  logic [LED_NUM-1:0] sw;
  logic timer_reset, timer_up, timer_enable, rng_advance, game_over;
  logic [LED_NUM-1:0] led_on;
  logic [SW-1:0] score, round_idx;
  logic [LW-1:0] lives;

  int total = 0;
  int passed = 0;

  whack_round_scheduler #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .reset(reset), .start(start), .timer_value(tv),
    .random_value(rv), .switches(sw), .timer_reset(timer_reset),
    .timer_up(timer_up), .timer_enable(timer_enable), .rng_advance(rng_advance),
    .led_on(led_on), .score(score), .lives(lives), .round_idx(round_idx),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // The shared ms timer the scheduler controls.
  always @(posedge clk) begin
    if (timer_reset) tv <= '0;
    else if (timer_enable && tv < TW'(MAX_MS)) tv <= tv + 1'b1;
  end

  // ---------------- game model ----------------
  bit m_valid = 0;
  bit m_live, m_lit, m_over, m_start_prev;
  int m_res;                      // 0 none, 1 hit pending, 2 miss pending
  int m_score, m_lives, m_round, m_on;
  logic [LED_NUM-1:0] m_target, m_snap;

  always @(posedge clk) begin
    logic [LED_NUM-1:0] one, diff;
    bit st_edge, done;
    one = 1;
    if (reset) begin
      m_valid = 1; m_live = 0; m_lit = 0; m_over = 0; m_res = 0;
      m_score = 0; m_lives = 0; m_round = 0; m_on = 0;
      m_target = '0; m_snap = '0; m_start_prev = 1;
    end else begin
      st_edge = start && !m_start_prev;
      m_start_prev = start;
      if (m_res != 0) begin
        m_round = m_round + 1;
        if (m_res == 1) begin
          m_score = m_score + 1;
          m_on = (m_on - STEP < MIN_ON) ? MIN_ON : m_on - STEP;
          done = (m_round == ROUNDS);
        end else begin
          m_lives = m_lives - 1;
          done = (m_lives == 0) || (m_round == ROUNDS);
        end
        m_res = 0; m_lit = 0;
        if (done) begin m_live = 0; m_over = 1; end
      end else if (m_lit) begin
        diff = sw ^ m_snap;
        if (diff == m_target) m_res = 1;
        else if (diff != 0 || int'(tv) >= m_on) m_res = 2;
      end else if (m_live) begin
        if (int'(tv) == GAP) begin
          m_target = one << (int'(rv) % LED_NUM);
          m_snap = sw;
          m_lit = 1;
        end
      end else if (st_edge) begin
        m_live = 1; m_over = 0; m_lives = MAX_LIVES; m_score = 0;
        m_round = 0; m_on = START_ON;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic e_tr, e_en, e_rng, e_ov;
    logic [LED_NUM-1:0] e_led;
    #1;
    if (m_valid) begin
      e_tr = 0; e_en = 0; e_rng = 0; e_ov = 0; e_led = '0;
      if (m_res != 0) begin e_tr = 1; e_rng = !reset; end
      else if (m_lit) begin e_en = 1; e_led = m_target; end
      else if (m_live) begin e_en = 1; e_tr = (int'(tv) == GAP); end
      else if (m_over) begin e_ov = 1; e_led = '1; end
      else e_tr = 1;
      check("outputs",
            64'({timer_reset, timer_up, timer_enable, rng_advance, game_over, led_on, score, lives, round_idx}),
            64'({e_tr, 1'b1, e_en, e_rng, e_ov, e_led, SW'(m_score), LW'(m_lives), SW'(m_round)}));
    end
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic wait_gap_end();
    bit found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (int'(tv) == GAP && m_live && !m_lit && m_res == 0) begin found = 1; break; end
      step();
    end
    if (!found) check("wait_gap_end", 64'(0), 64'(1));
  endtask

  task automatic wait_tv(input int v);
    bit found = 0;
    for (int i = 0; i < 2100; i++) begin
      if (int'(tv) == v) begin found = 1; break; end
      step();
    end
    if (!found) check("wait_tv", 64'(0), 64'(1));
  endtask

  task automatic start_edge_pulse();
    start = 0; step(); start = 1; step();
  endtask

  initial begin
    int react, kind;
    bit prev_lit, seen;
    logic [LED_NUM-1:0] one;
    one = 1;
    reset = 1; start = 1; sw = '0; rv = 5;
    repeat (3) step();
    reset = 0;
    repeat (4) step();
    check("held_start_idle_en", 64'(timer_enable), 64'(0));
    check("held_start_idle_lives", 64'(lives), 64'(0));
    check("idle_treset", 64'(timer_reset), 64'(1));
    start_edge_pulse();
    check("start_lives", 64'(lives), 64'(3));
    check("start_gap_en", 64'(timer_enable), 64'(1));

    // round 0: hit at 200
    wait_gap_end();
    check("gap_end_treset", 64'(timer_reset), 64'(1));
    step();
    check("target5_led", 64'(led_on), 64'(18'h00020));
    wait_tv(200);
    sw[5] = ~sw[5];
    step();
    check("hit_rng", 64'(rng_advance), 64'(1));
    check("hit_score_not_yet", 64'(score), 64'(0));
    step();
    check("hit_score", 64'(score), 64'(1));
    check("rng_single", 64'(rng_advance), 64'(0));
    check("hit_round", 64'(round_idx), 64'(1));

    // round 1: timeout at on_time 925
    wait_gap_end(); step();
    wait_tv(925);
    check("on925_no_miss_yet", 64'(rng_advance), 64'(0));
    step();
    check("miss_at_925", 64'(rng_advance), 64'(1));
    step();
    check("miss_lives", 64'(lives), 64'(2));
    check("miss_round", 64'(round_idx), 64'(2));
    check("miss_score", 64'(score), 64'(1));

    // round 2: extra switch -> miss
    wait_gap_end(); step();
    sw = sw ^ 18'h000A0;
    step();
    check("double_toggle_miss", 64'(rng_advance), 64'(1));
    step();
    check("double_toggle_lives", 64'(lives), 64'(1));

    // round 3: toggle on the timeout cycle -> hit wins
    wait_gap_end(); step();
    wait_tv(925);
    sw[5] = ~sw[5];
    step(); step();
    check("priority_hit_score", 64'(score), 64'(2));
    check("priority_hit_lives", 64'(lives), 64'(1));

    // round 4: last life lost
    wait_gap_end(); step();
    seen = 0;
    for (int i = 0; i < 1200; i++) begin
      if (game_over) begin seen = 1; break; end
      step();
    end
    check("over_reached", 64'(seen), 64'(1));
    check("over_lives", 64'(lives), 64'(0));
    check("over_led", 64'(led_on), 64'(18'h3FFFF));
    check("over_score", 64'(score), 64'(2));
    check("over_round", 64'(round_idx), 64'(5));

    start_edge_pulse();
    check("restart_lives", 64'(lives), 64'(3));
    check("restart_score", 64'(score), 64'(0));
    check("restart_over", 64'(game_over), 64'(0));

    // reset during SHOW
    wait_gap_end(); step(); step();
    check("show_led", 64'(led_on), 64'(18'h00020));
    reset = 1;
    step();
    check("reset_show_led", 64'(led_on), 64'(0));
    check("reset_show_treset", 64'(timer_reset), 64'(1));
    reset = 0;
    start_edge_pulse();

    // game A: 11 hits on the timeout cycle, then timeout at clamped 250
    for (int r = 0; r < ROUNDS - 1; r++) begin
      wait_gap_end(); step();
      wait_tv(m_on);
      sw = sw ^ m_target;
      step();
    end
    wait_gap_end(); step();
    wait_tv(250);
    check("clamp_not_yet", 64'(rng_advance), 64'(0));
    step();
    check("clamp_miss_250", 64'(rng_advance), 64'(1));
    step();
    check("gameA_over", 64'(game_over), 64'(1));
    check("gameA_score", 64'(score), 64'(11));
    check("gameA_round", 64'(round_idx), 64'(12));

    // game B: every round hit
    start_edge_pulse();
    for (int r = 0; r < ROUNDS; r++) begin
      wait_gap_end(); step();
      wait_tv(3);
      sw = sw ^ m_target;
      step();
    end
    step();
    check("gameB_score", 64'(score), 64'(ROUNDS));
    check("gameB_over", 64'(game_over), 64'(1));
    check("gameB_led", 64'(led_on), 64'(18'h3FFFF));
    check("gameB_lives", 64'(lives), 64'(3));

    // randomized play
    prev_lit = 0; react = 0; kind = 0;
    for (int c = 0; c < 25000; c++) begin
      step();
      if (m_lit && m_res == 0 && !prev_lit) begin
        react = $urandom_range(0, 400);
        kind = $urandom_range(0, 3);
      end
      prev_lit = m_lit && m_res == 0;
      if (m_lit && m_res == 0 && int'(tv) == react) begin
        if (kind == 1) sw = sw ^ (m_target | (one << $urandom_range(0, LED_NUM - 1)));
        else if (kind != 2) sw = sw ^ m_target;
      end
      if (!m_live && $urandom_range(0, 9) == 0) start = ~start;
      if (m_live && !m_lit && $urandom_range(0, 63) == 0) sw = sw ^ (one << $urandom_range(0, LED_NUM - 1));
      rv = IW'($urandom_range(0, 31));
      reset = ($urandom_range(0, 2999) == 0);
    end
    reset = 0;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
